// File: rtl/ntt_pkg.sv
// Shared NTT definitions: bridge FSM states and the processor geometry constants.
package ntt_pkg;

  localparam int NTT_DEPTH = 8;
  localparam int NTT_ROUND = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_READ,
    ST_RESP
  } ntt_state_e;

endpackage

// File: rtl/ntt_io_bridge_fifo.sv
// First-word-fall-through synchronous FIFO; head word is presented whenever not empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head is forced to zero when empty so the output never shows stale storage.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ntt_io_bridge.sv
// Host-side bridge for one NTT processor: load DEPTH words, start, wait, burst-read, buffer results.
module ntt_io_bridge
  import ntt_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = NTT_DEPTH,
  parameter int RD_LATENCY     = 2,
  parameter int COMPUTE_CYCLES = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] proc_din,
  output logic             proc_din_valid,
  output logic             proc_start,
  output logic             proc_read_valid,
  input  logic [WIDTH-1:0] proc_dout,
  input  logic             proc_dout_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(COMPUTE_CYCLES) + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C    = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LAT_C     = CW'(RD_LATENCY);
  localparam logic [WW-1:0] WAIT_LAST = WW'(COMPUTE_CYCLES - 1);

  ntt_state_e       state_q, state_d;
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic [CW-1:0]    rcnt_q, rcnt_d;
  logic [CW-1:0]    ocnt_q, ocnt_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             rdy_en_q;
  logic             accept;
  logic             push;
  logic             stray;
  logic             resp_window;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] din_p1;
  logic             vld_p1;
  logic             err_q;

  // Responses start arriving RD_LATENCY cycles into the read burst, so the
  // legal window spans the tail of READ plus all of RESP.
  assign resp_window = ((state_q == ST_READ) && (rcnt_q >= LAT_C)) ||
                       (state_q == ST_RESP);

  always_comb begin
    state_d         = state_q;
    wcnt_d          = wcnt_q;
    rcnt_d          = rcnt_q;
    ocnt_d          = ocnt_q;
    wait_d          = wait_q;
    s_ready         = 1'b0;
    accept          = 1'b0;
    proc_start      = 1'b0;
    proc_read_valid = 1'b0;
    push            = 1'b0;
    done            = 1'b0;
    stray           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_ready = rdy_en_q;
        if (s_valid && rdy_en_q) begin
          accept  = 1'b1;
          wcnt_d  = CW'(1);
          state_d = (DEPTH == 1) ? ST_START : ST_LOAD;
        end
      end
      ST_LOAD: begin
        s_ready = (wcnt_q < DEPTH_C);
        if (s_valid && s_ready) begin
          accept = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST_C) state_d = ST_START;
        end
      end
      ST_START: begin
        proc_start = 1'b1;
        wait_d     = '0;
        ocnt_d     = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // An empty FIFO guarantees room for the whole burst, so reads never stall.
        if (wait_q != WAIT_LAST) begin
          wait_d = wait_q + 1'b1;
        end else if (fifo_empty) begin
          rcnt_d  = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        proc_read_valid = 1'b1;
        rcnt_d          = rcnt_q + 1'b1;
        if (rcnt_q == LAST_C) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase

    if (proc_dout_valid) begin
      if (resp_window && !fifo_full) begin
        push   = 1'b1;
        ocnt_d = ocnt_q + 1'b1;
        if (ocnt_q == LAST_C) begin
          done    = 1'b1;
          ocnt_d  = '0;
          state_d = ST_IDLE;
        end
      end else begin
        stray = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      ocnt_q   <= '0;
      wait_q   <= '0;
      rdy_en_q <= 1'b0;
      err_q    <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      ocnt_q   <= ocnt_d;
      wait_q   <= wait_d;
      rdy_en_q <= 1'b1;
      vld_p1   <= accept;
      if (stray) err_q <= 1'b1;
    end
  end

  // Stage p1: accepted coefficient registered toward the processor write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_p1 <= '0;
    end else if (accept) begin
      din_p1 <= s_data;
    end
  end

  sync_fifo_fwft #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (proc_dout),
    .pop  (m_ready),
    .dout (m_data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign m_valid        = ~fifo_empty;
  assign proc_din       = din_p1;
  assign proc_din_valid = vld_p1;
  assign busy           = (state_q != ST_IDLE);
  assign err            = err_q;

endmodule

// File: tb/tb_ntt_io_bridge.sv
// Directed scoreboard bench for ntt_io_bridge with a 2-cycle-latency processor model (result = x + 100).
module tb_ntt_io_bridge;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CC    = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] proc_din;
  logic             proc_din_valid;
  logic             proc_start;
  logic             proc_read_valid;
  logic [WIDTH-1:0] proc_dout;
  logic             proc_dout_valid;
  logic             busy;
  logic             done;
  logic             err;

  ntt_io_bridge #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(2), .COMPUTE_CYCLES(CC)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .proc_din(proc_din), .proc_din_valid(proc_din_valid),
    .proc_start(proc_start), .proc_read_valid(proc_read_valid),
    .proc_dout(proc_dout), .proc_dout_valid(proc_dout_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] din_exp [$];
  logic [31:0] res_exp [$];
  int din_strobes = 0, din_rises = 0, starts = 0, reads_total = 0;
  int burst_len = 0, read_gap = 0, start_cyc = 0, dones = 0, m_count = 0, cyc = 0;
  logic prev_dv = 1'b0, prev_rv = 1'b0;
  logic stray_inj = 1'b0;

  // Processor model: wrapping write/read address, two-stage read pipeline.
  logic [31:0] pmem [DEPTH];
  logic [2:0]  waddr, raddr, a1;
  logic        v1, v2;
  logic [31:0] d2;

  always @(posedge clk) begin
    if (rst) begin
      waddr <= '0; raddr <= '0; a1 <= '0; v1 <= 1'b0; v2 <= 1'b0; d2 <= '0;
    end else begin
      if (proc_din_valid) begin
        pmem[waddr] <= proc_din;
        waddr <= waddr + 3'd1;
      end
      v1 <= proc_read_valid;
      a1 <= raddr;
      if (proc_read_valid) raddr <= raddr + 3'd1;
      v2 <= v1;
      d2 <= pmem[a1] + 32'd100;
    end
  end

  assign proc_dout_valid = v2 | stray_inj;
  assign proc_dout       = stray_inj ? 32'hDEAD : d2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (proc_din_valid) begin
        din_strobes++;
        if (!prev_dv) din_rises++;
        if (din_exp.size() == 0) check("din_extra", {31'd0, proc_din_valid}, 32'd0);
        else check("din_data", proc_din, din_exp.pop_front());
      end
      if (proc_start) begin
        starts++;
        start_cyc = cyc;
      end
      if (proc_read_valid) begin
        reads_total++;
        if (!prev_rv) begin
          burst_len = 0;
          read_gap  = cyc - start_cyc;
        end
        burst_len++;
      end
      if (done) dones++;
      if (m_valid && m_ready) begin
        m_count++;
        if (res_exp.size() == 0) check("m_extra", {31'd0, m_valid}, 32'd0);
        else check("m_data", m_data, res_exp.pop_front());
      end
    end
    prev_dv = proc_din_valid;
    prev_rv = proc_read_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] x);
    logic ok;
    ok = 1'b0;
    s_data  = x;
    s_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_ready", {31'd0, s_ready}, 32'd1);
    else begin
      din_exp.push_back(x);
      res_exp.push_back(x + 32'd100);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1;
      if (!busy && res_exp.size() == 0) break;
    end
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_drained"}, res_exp.size(), 32'd0);
  endtask

  int s0, r0, d0, m0, w0, t0;

  initial begin
    rst = 1'b1; s_valid = 1'b1; s_data = 32'd5; m_ready = 1'b1;

    // 1: reset with s_valid held high
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_ctrl", {24'd0, m_valid, proc_din_valid, proc_start, proc_read_valid,
                       busy, done, err, 1'b0}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_proc_din", proc_din, 32'd0);
    rst = 1'b0;
    s_valid = 1'b0;
    idle_cycle();
    check("rel_s_ready", {31'd0, s_ready}, 32'd1);

    // 2: basic back-to-back job
    s0 = starts; d0 = dones; m0 = m_count; w0 = din_strobes; t0 = din_rises;
    for (int i = 1; i <= 8; i++) send(32'(i));
    wait_idle("basic");
    check("basic_writes", din_strobes - w0, 32'd8);
    check("basic_rises", din_rises - t0, 32'd1);
    check("basic_starts", starts - s0, 32'd1);
    check("basic_burst", burst_len, 32'd8);
    check("basic_gap_ge24", {31'd0, read_gap >= CC}, 32'd1);
    check("basic_done", dones - d0, 32'd1);
    check("basic_mcount", m_count - m0, 32'd8);

    // 3: bubbly input
    s0 = starts; w0 = din_strobes; t0 = din_rises;
    for (int i = 0; i < 8; i++) begin
      send(32'h50 + 32'(i));
      idle_cycle();
    end
    wait_idle("bubbly");
    check("bubbly_writes", din_strobes - w0, 32'd8);
    check("bubbly_rises", din_rises - t0, 32'd8);
    check("bubbly_starts", starts - s0, 32'd1);
    check("bubbly_burst", burst_len, 32'd8);

    // 4: backpressure holds job 2 in WAIT until the FIFO drains
    m_ready = 1'b0;
    d0 = dones; m0 = m_count;
    for (int i = 0; i < 8; i++) send(32'h110 + 32'(i));
    for (int n = 0; n < 300; n++) begin
      idle_cycle();
      if (dones != d0) break;
    end
    check("bp_job1_done", dones - d0, 32'd1);
    check("bp_full_valid", {31'd0, m_valid}, 32'd1);
    for (int i = 0; i < 8; i++) send(32'h220 + 32'(i));
    r0 = reads_total;
    repeat (60) idle_cycle();
    check("bp_no_read", reads_total - r0, 32'd0);
    check("bp_busy", {31'd0, busy}, 32'd1);
    check("bp_held_mcount", m_count - m0, 32'd0);
    m_ready = 1'b1;
    wait_idle("bp");
    check("bp_reads", reads_total - r0, 32'd8);
    check("bp_dones", dones - d0, 32'd2);
    check("bp_mcount", m_count - m0, 32'd16);
    check("bp_err_clean", {31'd0, err}, 32'd0);

    // 5: stray response in IDLE
    stray_inj = 1'b1;
    idle_cycle();
    stray_inj = 1'b0;
    check("stray_err", {31'd0, err}, 32'd1);
    check("stray_fifo", {31'd0, m_valid}, 32'd0);
    repeat (3) idle_cycle();
    check("stray_sticky", {31'd0, err}, 32'd1);

    // 6: reset during READ cycle 4, then a fresh job
    for (int i = 0; i < 8; i++) send(32'h330 + 32'(i));
    for (int n = 0; n < 300; n++) begin
      idle_cycle();
      if (proc_read_valid && burst_len == 3) break;
    end
    check("mid_in_read4", {31'd0, proc_read_valid}, 32'd1);
    rst = 1'b1;
    idle_cycle();
    check("mid_rv_off", {31'd0, proc_read_valid}, 32'd0);
    check("mid_fifo_empty", {31'd0, m_valid}, 32'd0);
    check("mid_err_clr", {31'd0, err}, 32'd0);
    res_exp.delete();
    din_exp.delete();
    rst = 1'b0;
    idle_cycle();
    s0 = starts; d0 = dones; m0 = m_count;
    for (int i = 0; i < 8; i++) send(32'h440 + 32'(i));
    wait_idle("fresh");
    check("fresh_starts", starts - s0, 32'd1);
    check("fresh_done", dones - d0, 32'd1);
    check("fresh_mcount", m_count - m0, 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
